// File: rtl/spi_pkg.sv
// Shared types for the SPI slave: FSM state encoding and per-frame mode bundle.
// Latency: n/a (types only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spi_slv_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic msb_lsb;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser for asynchronous SPI pins into clk.
// Latency: STAGES clk from input change to q.
// Backpressure: none; free-running, reset to RST_VAL.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the raw pin through the flop chain; the last flop is the clean copy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint oversampled on clk; shifts DW-bit frames per cpol/cpha/msb_lsb.
// Latency: cs fall -> tx_load SYNC_STAGES+2 clk; frame completion -> rx_valid via DONE state.
// Backpressure: rx_valid held until rx_ack; an unacked frame is overwritten by the next one
// (optional sticky ovr flag when built with SPI_SLAVE_OVR_EN).
module spi_slave
    import spi_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          tr_en,
    input  logic          cpol,
    input  logic          cpha,
    input  logic          msb_lsb,
    input  logic [DW-1:0] tx_data,
    output logic          tx_load,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ack,
    output logic          busy,
    input  logic          sck,
    input  logic          cs,
    input  logic          mosi,
    output logic          miso
`ifdef SPI_SLAVE_OVR_EN
    ,
    output logic          ovr,
    input  logic          ovr_clr
`endif
);

    localparam int           CW   = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic sck_s, cs_s, mosi_s;
    logic sck_p, cs_p;
    logic sck_rise, sck_fall, cs_fall, cs_rise;
    logic lead, trail, smp_edge, shf_edge;

    spi_slv_state_t state;
    spi_mode_t      mode;
    logic [CW-1:0]  bit_c;
    logic [DW-1:0]  tx_sr;
    logic [DW-1:0]  rx_sr;

    // Bit that goes on the wire first for the given order.
    function automatic logic first_bit(input logic [DW-1:0] v, input logic msb);
        return msb ? v[DW-1] : v[0];
    endfunction

    // Drop the bit just sent and move the next one into the output position.
    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] v, input logic msb);
        return msb ? {v[DW-2:0], 1'b0} : {1'b0, v[DW-1:1]};
    endfunction

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .resetn(resetn), .d(sck), .q(sck_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .resetn(resetn), .d(cs), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
        .clk(clk), .resetn(resetn), .d(mosi), .q(mosi_s)
    );

    // Remember last synchronised sck/cs so edges can be detected.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_p <= 1'b0;
            cs_p  <= 1'b1;
        end else if (!tr_en) begin
            sck_p <= 1'b0;
            cs_p  <= 1'b1;
        end else begin
            sck_p <= sck_s;
            cs_p  <= cs_s;
        end
    end

    // Edge classification relative to the mode latched for this frame.
    always_comb begin
        sck_rise = sck_s & ~sck_p;
        sck_fall = ~sck_s & sck_p;
        cs_fall  = cs_p & ~cs_s;
        cs_rise  = ~cs_p & cs_s;
        lead     = mode.cpol ? sck_fall : sck_rise;
        trail    = mode.cpol ? sck_rise : sck_fall;
        smp_edge = mode.cpha ? trail : lead;
        shf_edge = mode.cpha ? lead : trail;
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            mode     <= '0;
            bit_c    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            busy     <= 1'b0;
            miso     <= 1'b1;
        end else if (!tr_en) begin
            state    <= IDLE;
            mode     <= '0;
            bit_c    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            busy     <= 1'b0;
            miso     <= 1'b1;
        end else begin
            tx_load <= 1'b0;
            // Ack only clears a pending frame; a completion in DONE below takes priority.
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end
            if (cs_rise && state != DONE) begin
                state <= IDLE;
                busy  <= 1'b0;
                miso  <= 1'b1;
                bit_c <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            mode  <= '{cpol: cpol, cpha: cpha, msb_lsb: msb_lsb};
                            busy  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        tx_load <= 1'b1;
                        bit_c   <= '0;
                        if (!mode.cpha) begin
                            miso  <= first_bit(tx_data, mode.msb_lsb);
                            tx_sr <= shift_out(tx_data, mode.msb_lsb);
                        end else begin
                            tx_sr <= tx_data;
                        end
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        if (smp_edge) begin
                            rx_sr <= mode.msb_lsb ? {rx_sr[DW-2:0], mosi_s}
                                                  : {mosi_s, rx_sr[DW-1:1]};
                            bit_c <= (bit_c == LAST) ? '0 : bit_c + CW'(1);
                            if (bit_c == LAST) begin
                                state <= DONE;
                            end
                        end
                        // With cpha=0 the first bit is already on miso, so the trailing
                        // edge at bit_c==0 (tail of the previous frame) must not advance it.
                        if (shf_edge && (mode.cpha || bit_c != '0)) begin
                            miso  <= first_bit(tx_sr, mode.msb_lsb);
                            tx_sr <= shift_out(tx_sr, mode.msb_lsb);
                        end
                    end
                    DONE: begin
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        bit_c    <= '0;
                        if (!cs_s) begin
                            tx_load <= 1'b1;
                            if (!mode.cpha) begin
                                miso  <= first_bit(tx_data, mode.msb_lsb);
                                tx_sr <= shift_out(tx_data, mode.msb_lsb);
                            end else begin
                                tx_sr <= tx_data;
                            end
                            state <= SHIFT;
                        end else begin
                            busy  <= 1'b0;
                            miso  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_OVR_EN
    // Sticky overrun: a frame landed on top of an unacknowledged one; set beats clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovr <= 1'b0;
        end else if (!tr_en) begin
            ovr <= 1'b0;
        end else if (state == DONE && rx_valid && !rx_ack) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end
`endif

endmodule
